// File: rtl/counter_ctrl_unit_if.sv
// Button-pulse inputs and counter-control outputs of counter_ctrl_unit.
// master drives the pulses, slave is the control unit.
interface counter_ctrl_unit_if;
  logic       i_run_stop;
  logic       i_clear;
  logic       i_mode;
  logic       o_tick;
  logic       o_clear;
  logic       o_down;
  logic [1:0] o_state;

  modport master (
    output i_run_stop, i_clear, i_mode,
    input  o_tick, o_clear, o_down, o_state
  );

  modport slave (
    input  i_run_stop, i_clear, i_mode,
    output o_tick, o_clear, o_down, o_state
  );
endinterface

// File: rtl/counter_ctrl_unit.sv
// Run/stop/clear FSM, direction register and prescaled
// count-enable tick for the 14-bit up/down counter.
module counter_ctrl_unit #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 10
) (
  input  logic               clk,
  input  logic               reset,
  counter_ctrl_unit_if.slave bus
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          down_q;
  logic          run_hold;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STOP: begin
        if (bus.i_clear)         state_d = ST_CLEAR;
        else if (bus.i_run_stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.i_clear)         state_d = ST_CLEAR;
        else if (bus.i_run_stop) state_d = ST_STOP;
      end
      ST_CLEAR: state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
  end

  // Leaving RUN freezes the prescaler, so a stop at DIV-1
  // defers the tick to the first cycle after resume.
  assign run_hold = (state_q == ST_RUN) &&
                    (state_d == ST_RUN);

  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (state_q == ST_CLEAR) begin
      presc_d = '0;
    end else if (run_hold) begin
      if (presc_q == LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_STOP;
      presc_q <= '0;
      tick_q  <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      down_q  <= down_q ^ bus.i_mode;
    end
  end

  assign bus.o_tick  = tick_q;
  assign bus.o_clear = (state_q == ST_CLEAR);
  assign bus.o_down  = down_q;
  assign bus.o_state = state_q;

endmodule

// File: tb/tb_counter_ctrl_unit.sv
// Directed scenarios plus randomized pulses checked every
// cycle against a behavioural model of the control unit.
module tb_counter_ctrl_unit;

  localparam int DIV = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  counter_ctrl_unit_if bus ();

  counter_ctrl_unit #(
    .CLK_HZ (100),
    .TICK_HZ(10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // model: 0 = STOP, 1 = RUN, 2 = CLEAR
  int m_state;
  int m_runs;
  bit m_tick;
  bit m_down;

  always @(posedge clk or posedge reset) begin
    int nxt;
    if (reset) begin
      m_state = 0;
      m_runs  = 0;
      m_tick  = 0;
      m_down  = 0;
    end else begin
      if (m_state == 2)          nxt = 0;
      else if (bus.i_clear)      nxt = 2;
      else if (bus.i_run_stop)   nxt = 1 - m_state;
      else                       nxt = m_state;
      m_tick = 0;
      if (m_state == 1 && nxt == 1) begin
        m_runs = (m_runs + 1) % DIV;
        m_tick = (m_runs == 0);
      end
      if (m_state == 2) m_runs = 0;
      if (bus.i_mode) m_down = !m_down;
      m_state = nxt;
    end
  end

  always @(negedge clk) begin
    chk("state", 32'(bus.o_state), 32'(m_state));
    chk("tick",  32'(bus.o_tick),  32'(m_tick));
    chk("clear", 32'(bus.o_clear), 32'(m_state == 2));
    chk("down",  32'(bus.o_down),  32'(m_down));
  end

  task automatic pulse(bit rs, bit cl, bit md);
    bus.i_run_stop = rs;
    bus.i_clear    = cl;
    bus.i_mode     = md;
    @(negedge clk);
    bus.i_run_stop = 1'b0;
    bus.i_clear    = 1'b0;
    bus.i_mode     = 1'b0;
  endtask

  task automatic run_cycles(int n, output int cnt,
                            output int first);
    cnt   = 0;
    first = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (bus.o_tick) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
  endtask

  initial begin
    int c, f;
    reset          = 1'b1;
    bus.i_run_stop = 1'b0;
    bus.i_clear    = 1'b0;
    bus.i_mode     = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_state", 32'(bus.o_state), 0);
    chk("rst_tick",  32'(bus.o_tick),  0);
    chk("rst_clear", 32'(bus.o_clear), 0);
    chk("rst_down",  32'(bus.o_down),  0);
    run_cycles(50, c, f);
    chk("idle_ticks", c, 0);

    pulse(1, 0, 0);
    chk("run_state", 32'(bus.o_state), 1);
    run_cycles(50, c, f);
    chk("run_first", f, 10);
    chk("run_count", c, 5);

    run_cycles(4, c, f);
    pulse(1, 0, 0);
    chk("stop_state", 32'(bus.o_state), 0);
    run_cycles(20, c, f);
    chk("stop_ticks", c, 0);
    pulse(1, 0, 0);
    run_cycles(10, c, f);
    chk("resume_first", f, 6);

    pulse(0, 1, 0);
    chk("clr_state", 32'(bus.o_state), 2);
    chk("clr_strobe", 32'(bus.o_clear), 1);
    @(negedge clk);
    chk("clr_after", 32'(bus.o_state), 0);
    chk("clr_strobe_off", 32'(bus.o_clear), 0);
    pulse(1, 0, 0);
    run_cycles(12, c, f);
    chk("clr_first", f, 10);

    pulse(1, 0, 0);
    chk("sim_down_pre", 32'(bus.o_down), 0);
    pulse(1, 1, 1);
    chk("sim_state", 32'(bus.o_state), 2);
    chk("sim_down", 32'(bus.o_down), 1);
    @(negedge clk);
    chk("sim_stop", 32'(bus.o_state), 0);

    pulse(1, 0, 0);
    run_cycles(3, c, f);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", 32'(bus.o_state), 0);
    chk("arst_tick",  32'(bus.o_tick),  0);
    chk("arst_clear", 32'(bus.o_clear), 0);
    chk("arst_down",  32'(bus.o_down),  0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
      end else begin
        bus.i_run_stop = ($urandom_range(0, 7) == 0);
        bus.i_clear    = ($urandom_range(0, 24) == 0);
        bus.i_mode     = ($urandom_range(0, 11) == 0);
        @(negedge clk);
      end
    end
    bus.i_run_stop = 1'b0;
    bus.i_clear    = 1'b0;
    bus.i_mode     = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
